seq_run_ctrl: RTL and testbench

- Controller that sequences a 3-bit custom-sequence counter (code order 000 -> 010 -> 011 -> 101 -> 111 -> 000) for a programmed number of steps.
- Uses a start/busy/done handshake, with pause and abort.
- Sits between a host sequencer and the counter datapath: the counter advances only when this block enables it, and the block reports completion and sequence wrap.

---
 rtl/seq_run_ctrl_pkg.sv | 29 ++
 rtl/seq_run_ctrl_if.sv | 25 ++
 rtl/seq_run_ctrl_core.sv | 41 ++++
 rtl/seq_run_ctrl.sv | 85 ++++++++
 tb/tb_seq_run_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/seq_run_ctrl_pkg.sv
// Shared constants for the run controller: FSM state encoding, sequence codes
// and the next-code function of the custom 3-bit sequence.
package seq_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [2:0] S0 = 3'b000;
  localparam logic [2:0] S1 = 3'b010;
  localparam logic [2:0] S2 = 3'b011;
  localparam logic [2:0] S3 = 3'b101;
  localparam logic [2:0] S4 = 3'b111;

  // Codes outside the sequence fall back to S0 so a corrupted counter recovers.
  function automatic logic [2:0] next_code(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      S0:      nxt = S1;
      S1:      nxt = S2;
      S2:      nxt = S3;
      S3:      nxt = S4;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/seq_run_ctrl_if.sv
// Host-side handshake bundle of the run controller: run request inputs and
// the registered status outputs.
interface seq_run_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             pause;
  logic             abort;
  logic [2:0]       q;
  logic             busy;
  logic             done;
  logic             wrap;
  logic [CNT_W-1:0] step_cnt;

  modport master (
    output start, len, pause, abort,
    input  q, busy, done, wrap, step_cnt
  );

  modport slave (
    input  start, len, pause, abort,
    output q, busy, done, wrap, step_cnt
  );
endinterface

// File: rtl/seq_run_ctrl_core.sv
// Sequence counter datapath: holds the current code, advances on en, clears
// on clr (clr wins) and flags the 111->000 transition one cycle later.
module seq_core
  import seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic [2:0] q,
  output logic       wrap
);

  logic [2:0] q_d, q_q;
  logic       wrap_d, wrap_q;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (clr) begin
      q_d = S0;
    end else if (en) begin
      q_d    = next_code(q_q);
      wrap_d = (q_q == S4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= S0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/seq_run_ctrl.sv
// Run controller: accepts a start/len request, enables the sequence counter
// for len advances with pause/abort, and pulses done on normal completion.
module seq_run_ctrl
  import seq_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  seq_run_ctrl_if.slave bus
);

  logic [1:0]       state_d, state_q;
  logic [CNT_W-1:0] len_d, len_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             core_en, core_clr;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    core_en  = 1'b0;
    core_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            state_d  = RUN;
            len_d    = bus.len;
            cnt_d    = '0;
            core_clr = 1'b1;
          end else begin
            // Zero-length run completes at once, leaving q and step_cnt alone.
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.pause) begin
          state_d = PAUSE;
        end else begin
          core_en = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_d == len_q) state_d = DONE;
        end
      end
      PAUSE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (!bus.pause) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  seq_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (core_en),
    .clr   (core_clr),
    .q     (bus.q),
    .wrap  (bus.wrap)
  );

  assign bus.busy     = (state_q == RUN) || (state_q == PAUSE);
  assign bus.done     = (state_q == DONE);
  assign bus.step_cnt = cnt_q;

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Directed bench for seq_run_ctrl: each step drives inputs, queues the expected
// post-edge outputs, then pops and checks them after the clock edge.
module tb_seq_run_ctrl;

  typedef struct packed {
    logic [2:0] q;
    logic       busy;
    logic       done;
    logic       wrap;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];

  seq_run_ctrl_if #(.CNT_W(8)) bus ();

  seq_run_ctrl #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input logic [2:0] q, input logic busy, input logic done,
                          input logic wrap, input logic [7:0] cnt);
    exp_t e;
    e.q    = q;
    e.busy = busy;
    e.done = done;
    e.wrap = wrap;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed q=%b", tag, bus.q);
      return;
    end
    e = exp_q.pop_front();
    assert (bus.q === e.q) else begin
      n_fail++;
      $error("FAIL %s q: observed %b expected %b", tag, bus.q, e.q);
    end
    assert (bus.busy === e.busy) else begin
      n_fail++;
      $error("FAIL %s busy: observed %b expected %b", tag, bus.busy, e.busy);
    end
    assert (bus.done === e.done) else begin
      n_fail++;
      $error("FAIL %s done: observed %b expected %b", tag, bus.done, e.done);
    end
    assert (bus.wrap === e.wrap) else begin
      n_fail++;
      $error("FAIL %s wrap: observed %b expected %b", tag, bus.wrap, e.wrap);
    end
    assert (bus.step_cnt === e.cnt) else begin
      n_fail++;
      $error("FAIL %s step_cnt: observed %0d expected %0d", tag, bus.step_cnt, e.cnt);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the next edge.
  task automatic step(input string tag, input logic s, input logic [7:0] l, input logic p,
                      input logic a, input logic [2:0] q, input logic busy,
                      input logic done, input logic wrap, input logic [7:0] cnt);
    bus.start = s;
    bus.len   = l;
    bus.pause = p;
    bus.abort = a;
    push_exp(q, busy, done, wrap, cnt);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.len   = '0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;

    #3;
    push_exp(3'b000, 1'b0, 1'b0, 1'b0, 8'd0);
    check_out("reset");
    #9 rst_n = 1'b1;

    // len=5: full trip through the sequence, wrap on the last advance.
    step("l5_go",  1, 8'd5, 0, 0, 3'b000, 1, 0, 0, 8'd0);
    step("l5_a1",  0, 8'd0, 0, 0, 3'b010, 1, 0, 0, 8'd1);
    step("l5_a2",  0, 8'd0, 0, 0, 3'b011, 1, 0, 0, 8'd2);
    step("l5_a3",  0, 8'd0, 0, 0, 3'b101, 1, 0, 0, 8'd3);
    step("l5_a4",  0, 8'd0, 0, 0, 3'b111, 1, 0, 0, 8'd4);
    step("l5_a5",  0, 8'd0, 0, 0, 3'b000, 0, 1, 1, 8'd5);
    step("l5_idl", 0, 8'd0, 0, 0, 3'b000, 0, 0, 0, 8'd5);

    // len=3 with two pause cycles after the first advance.
    step("l3_go",  1, 8'd3, 0, 0, 3'b000, 1, 0, 0, 8'd0);
    step("l3_a1",  0, 8'd0, 0, 0, 3'b010, 1, 0, 0, 8'd1);
    step("l3_p1",  0, 8'd0, 1, 0, 3'b010, 1, 0, 0, 8'd1);
    step("l3_p2",  0, 8'd0, 1, 0, 3'b010, 1, 0, 0, 8'd1);
    step("l3_res", 0, 8'd0, 0, 0, 3'b010, 1, 0, 0, 8'd1);
    step("l3_a2",  0, 8'd0, 0, 0, 3'b011, 1, 0, 0, 8'd2);
    step("l3_a3",  0, 8'd0, 0, 0, 3'b101, 0, 1, 0, 8'd3);
    step("l3_idl", 0, 8'd0, 0, 0, 3'b101, 0, 0, 0, 8'd3);

    // len=7 aborted after three advances; abort also beats pause.
    step("l7_go",  1, 8'd7, 0, 0, 3'b000, 1, 0, 0, 8'd0);
    step("l7_a1",  0, 8'd0, 0, 0, 3'b010, 1, 0, 0, 8'd1);
    step("l7_a2",  0, 8'd0, 0, 0, 3'b011, 1, 0, 0, 8'd2);
    step("l7_a3",  0, 8'd0, 0, 0, 3'b101, 1, 0, 0, 8'd3);
    step("l7_ab",  0, 8'd0, 1, 1, 3'b101, 0, 0, 0, 8'd3);
    step("l7_idl", 0, 8'd0, 0, 0, 3'b101, 0, 0, 0, 8'd3);

    // len=0: straight to done, outputs held.
    step("l0_go",  1, 8'd0, 0, 0, 3'b101, 0, 1, 0, 8'd3);
    step("l0_idl", 0, 8'd0, 0, 0, 3'b101, 0, 0, 0, 8'd3);

    // start held high with len=2: DONE ignores start, IDLE re-accepts.
    step("h2_go",  1, 8'd2, 0, 0, 3'b000, 1, 0, 0, 8'd0);
    step("h2_a1",  1, 8'd2, 0, 0, 3'b010, 1, 0, 0, 8'd1);
    step("h2_a2",  1, 8'd2, 0, 0, 3'b011, 0, 1, 0, 8'd2);
    step("h2_dn",  1, 8'd2, 0, 0, 3'b011, 0, 0, 0, 8'd2);
    step("h2_re",  1, 8'd2, 0, 0, 3'b000, 1, 0, 0, 8'd0);
    step("h2_b1",  0, 8'd0, 0, 0, 3'b010, 1, 0, 0, 8'd1);
    step("h2_b2",  0, 8'd0, 0, 0, 3'b011, 0, 1, 0, 8'd2);
    step("h2_idl", 0, 8'd0, 0, 0, 3'b011, 0, 0, 0, 8'd2);

    // Asynchronous reset in the middle of a run, checked before the next edge.
    step("rs_go",  1, 8'd5, 0, 0, 3'b000, 1, 0, 0, 8'd0);
    step("rs_a1",  0, 8'd0, 0, 0, 3'b010, 1, 0, 0, 8'd1);
    step("rs_a2",  0, 8'd0, 0, 0, 3'b011, 1, 0, 0, 8'd2);
    #2 rst_n = 1'b0;
    #1;
    push_exp(3'b000, 1'b0, 1'b0, 1'b0, 8'd0);
    check_out("rs_async");
    #3 rst_n = 1'b1;
    step("rs_idl", 0, 8'd0, 0, 0, 3'b000, 0, 0, 0, 8'd0);
    step("rs_idl2", 0, 8'd0, 0, 0, 3'b000, 0, 0, 0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
